// File: rtl/pipe_pkg.sv
// Shared types for CPU pipeline stage registers: skid FSM states, per-stage
// field bundles and their packed widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // EX/MEM bundle: control bits first, then wide datapath words.
  typedef struct packed {
    logic        MemRead;
    logic        MemWrite;
    logic        DataMemExtendSign;
    logic        RegWrite;
    logic        RegWriteSel;
    logic        Zero;
    logic [1:0]  BHW;
    logic [1:0]  MemToReg;
    logic [1:0]  RegDst;
    logic [4:0]  WriteRegAddress;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] ALUResult;
    logic [31:0] NextInstruct;
    logic [31:0] Instruction;
  } ex_mem_fields_t;

  // IF/ID bundle: fetched instruction and its fall-through PC.
  typedef struct packed {
    logic [31:0] NextInstruct;
    logic [31:0] Instruction;
  } if_id_fields_t;

  localparam int unsigned EX_MEM_W = 177;
  localparam int unsigned IF_ID_W  = 64;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and flush.
// SKID=1: main+skid entries, registered in_ready (no out_ready->in_ready path).
// SKID=0: single entry, in_ready combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = EX_MEM_W,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    skid_state_t      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;
    logic             vld_q;
    logic [1:0]       occ_q;

    // Skid FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state  <= EMPTY;
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
        rdy_q  <= 1'b1;
        vld_q  <= 1'b0;
        occ_q  <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state  <= BUSY;
              main_q <= in_data;
              vld_q  <= 1'b1;
              occ_q  <= 2'd1;
            end
          end
          BUSY: begin
            if (in_fire && !out_fire) begin
              state  <= FULL;
              skid_q <= in_data;
              rdy_q  <= 1'b0;
              occ_q  <= 2'd2;
            end else if (in_fire) begin
              main_q <= in_data;
            end else if (out_fire) begin
              state <= EMPTY;
              vld_q <= 1'b0;
              occ_q <= '0;
            end
          end
          FULL: begin
            if (out_fire) begin
              state  <= BUSY;
              main_q <= skid_q;
              rdy_q  <= 1'b1;
              occ_q  <= 2'd1;
            end
          end
          default: begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            occ_q  <= '0;
          end
        endcase
      end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

  end else begin : g_single
    logic [WIDTH-1:0] main_q;
    logic             vld_q;

    // Single entry: load on accept, clear when drained with nothing behind it.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_q <= RESET_VAL;
        vld_q  <= 1'b0;
      end else if (in_fire) begin
        main_q <= in_data;
        vld_q  <= 1'b1;
      end else if (out_fire) begin
        vld_q <= 1'b0;
      end
    end

    assign in_ready  = !vld_q | out_ready;
    assign out_valid = vld_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, vld_q};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share stimulus;
// per-instance scoreboards track accepted beats and check delivered ones.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned W = EX_MEM_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out_data1, out_data0;
  logic [1:0]   occ1, occ0;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .occupancy(occ0)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload with marker bits at both ends so top bits are exercised too.
  function automatic logic [W-1:0] v(input logic [31:0] x);
    logic [W-1:0] r;
    r = '0;
    r[31:0] = x;
    r[W-1 -: 8] = x[7:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare deliveries, then record acceptances, then flush.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      check("occ1_vs_sb", {{(W-2){1'b0}}, occ1}, W'(q1.size()));
      check("occ0_vs_sb", {{(W-2){1'b0}}, occ0}, W'(q0.size()));
      check("rdy1_not_full", {{(W-1){1'b0}}, in_ready1}, {{(W-1){1'b0}}, occ1 != 2'd2});
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb1_extra: got %0h expected no beat", out_data1);
        end else check("sb1_order", out_data1, q1.pop_front());
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb0_extra: got %0h expected no beat", out_data0);
        end else check("sb0_order", out_data0, q0.pop_front());
      end
      if (in_valid && in_ready1) q1.push_back(in_data);
      if (in_valid && in_ready0) q0.push_back(in_data);
      if (flush) begin
        q1.delete();
        q0.delete();
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = v(32'hFF); out_ready = 1'b1;

    // Reset held two cycles with a beat on the input.
    step(); step();
    check("rst_vld1", W'(out_valid1), '0);
    check("rst_data1", out_data1, '0);
    check("rst_occ1", W'(occ1), '0);
    check("rst_rdy1", W'(in_ready1), W'(1));
    check("rst_vld0", W'(out_valid0), '0);
    check("rst_occ0", W'(occ0), '0);
    rst = 1'b0; in_data = v(32'hA5);
    step();
    check("first_vld1", W'(out_valid1), W'(1));
    check("first_data1", out_data1, v(32'hA5));
    check("first_data0", out_data0, v(32'hA5));
    in_valid = 1'b0;
    step();

    // Streaming eight beats back to back.
    for (int unsigned i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = v(i);
      check("stream_rdy1", W'(in_ready1), W'(1));
      step();
      check("stream_data1", out_data1, v(i));
      check("stream_vld1", W'(out_valid1), W'(1));
    end
    in_valid = 1'b0;
    step(); step();

    // Stall: two beats fill main+skid.
    out_ready = 1'b0; in_valid = 1'b1; in_data = v(32'h11);
    step();
    check("stall_rdy_lag", W'(in_ready1), W'(1));
    in_data = v(32'h22);
    step();
    in_valid = 1'b0;
    check("stall_occ", W'(occ1), W'(2));
    check("stall_rdy", W'(in_ready1), '0);
    check("stall_data", out_data1, v(32'h11));
    step();
    check("stall_hold", out_data1, v(32'h11));
    check("stall_hold_vld", W'(out_valid1), W'(1));
    out_ready = 1'b1;
    #1;
    check("rdy1_no_comb", W'(in_ready1), '0);
    check("rdy0_comb", W'(in_ready0), W'(1));
    step();
    check("rel_data", out_data1, v(32'h22));
    check("rel_occ", W'(occ1), W'(1));
    check("rel_rdy", W'(in_ready1), W'(1));
    step();
    check("rel_empty", W'(out_valid1), '0);

    // Flush while FULL with a beat presented.
    out_ready = 1'b0; in_valid = 1'b1; in_data = v(32'h55);
    step();
    in_data = v(32'h66);
    step();
    flush = 1'b1; in_data = v(32'h33);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_vld", W'(out_valid1), '0);
    check("flush_occ", W'(occ1), '0);
    check("flush_data", out_data1, '0);
    check("flush_rdy", W'(in_ready1), W'(1));
    out_ready = 1'b1;
    step();
    check("flush_no33", W'(out_valid1), '0);

    // Flush while BUSY swallows the beat accepted in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = v(32'h77);
    step();
    flush = 1'b1; in_data = v(32'h88);
    step();
    flush = 1'b0;
    check("flush2_vld", W'(out_valid1), '0);
    in_data = v(32'h99);
    step();
    in_valid = 1'b0;
    check("post_flush_vld", W'(out_valid1), W'(1));
    check("post_flush_data", out_data1, v(32'h99));
    out_ready = 1'b1;
    step(); step();

    // Single-entry mode: replace held beat without a bubble.
    out_ready = 1'b0; in_valid = 1'b1; in_data = v(32'h40);
    step();
    check("s0_hold", out_data0, v(32'h40));
    check("s0_stall_rdy", W'(in_ready0), '0);
    out_ready = 1'b1; in_data = v(32'h44);
    #1;
    check("s0_same_rdy", W'(in_ready0), W'(1));
    step();
    in_valid = 1'b0;
    check("s0_vld", W'(out_valid0), W'(1));
    check("s0_data", out_data0, v(32'h44));
    step(); step();
    check("s0_empty", W'(out_valid0), '0);

    // Pseudo-random valid/ready/flush/reset traffic against the scoreboards.
    for (int unsigned c = 0; c < 4000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0 || c < 100);
      in_data   = v($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check("drain_q1", W'(q1.size()), '0);
    check("drain_q0", W'(q0.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
